fir_mac_seq: RTL
================

# fir_mac_seq

- Sequential FIR engine that drives the shared combinational `alu` as its multiplier.
- Accepts one signed sample per handshake and holds a TAPS-deep delay line plus a coefficient bank.
- Issues one multiply per tap to the ALU (`alu_sel`=1) and accumulates products internally.
- Presents the filter output on a valid/ready port; sits between the sample source and the FIR result consumer.

## Interface
- `N`, 16: sample/coefficient width (signed); must match ALU operand width.
- `TAPS`, 4: number of taps, 2..16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: sample valid.
- `in_data` in N: signed sample.
- `in_ready` out 1: block can accept a sample.
- `coef_we` in 1: coefficient write strobe.
- `coef_addr` in 4: tap index.
- `coef_data` in N: signed coefficient.
- `alu_a` out N: ALU operand a (delay-line sample).
- `alu_b` out N: ALU operand b (coefficient).
- `alu_sel` out 1: ALU op select, 1 = multiply.
- `alu_out` in 32: ALU result (combinational, same cycle).
- `out_valid` out 1: result valid.
- `out_data` out 32: signed filter output.
- `out_ready` in 1: consumer accepts result.

## Operation
- FSM states: IDLE, MAC, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid` the delay line shifts: x[0]←`in_data`, x[k]←x[k-1]. Tap counter k←0. Go to MAC.
- **MAC:** lasts TAPS cycles, k = 0..TAPS-1.
  - `alu_a`=x[k], `alu_b`=h[k], `alu_sel`=1.
  - acc ← (k==0 ? 0 : acc) + `alu_out`.
  - After k=TAPS-1, go to DONE.
- **DONE:**
  - `out_valid`=1, `out_data`=acc.
  - On `out_ready`, go to IDLE.
  - Otherwise hold; `out_data` is stable while `out_valid`=1.
- **Outside MAC:** `alu_a`=0, `alu_b`=0, `alu_sel`=0.
- **Arithmetic:** acc is 32-bit two's complement and wraps silently on overflow (no saturation). Products are taken as the full 32-bit `alu_out`.
- **Coefficient writes:**
  - Accepted only in IDLE; h[`coef_addr`]←`coef_data`, effective the next cycle.
  - Ignored in MAC/DONE, and ignored when `coef_addr` ≥ TAPS.
  - `coef_we` together with `in_valid` in the same IDLE cycle: the write is performed, and the MAC starting next cycle uses the new coefficient.
- **Reset (asynchronous, any state including mid-MAC):**
  - State → IDLE.
  - Delay line, coefficients, acc, k → 0.
  - `out_valid`=0, `out_data`=0, `alu_a`/`alu_b`/`alu_sel`=0.
  - `in_ready`=1 after release.
  - A partially computed result is discarded and never emitted.

## Timing
- Sample accepted at edge T (IDLE, `in_valid`=1).
- MAC occupies cycles T+1 … T+TAPS.
- `out_valid` rises at cycle T+TAPS+1.
- Latency is TAPS+1 cycles from the accept edge to `out_valid`.
- With `out_ready` held high:
  - DONE lasts 1 cycle, then IDLE for ≥1 cycle.
  - Throughput is 1 sample per TAPS+2 cycles.
- `in_ready` is 0 in MAC and DONE; `in_valid` there is ignored and not queued.
- `in_ready` and `out_valid` are never both 1.
- `alu_out` is sampled in the same cycle the operands are driven; there is no ALU pipeline stage.
- All outputs are registered except `in_ready` and the `alu_*` operands, which are decoded from state/k.

## Test plan
- **Impulse:** h={1,2,3,4}, inputs 1,0,0,0 with `out_ready`=1 → outputs 1,2,3,4; each `out_valid` rises 5 cycles after its accept.
- **Signed:** h={-3,0,0,0}, input -5 → 15. Then input 7 → -21 (x[1]=-5 contributes 0).
- **Overflow:** all h=-32768, four inputs of -32768 → 4th output 4·2^30 wraps to 0x00000000. 3rd output is 0xC0000000.
- **Backpressure:** `out_ready`=0 for 6 cycles after `out_valid` → `out_valid`/`out_data` held, `in_ready`=0, extra `in_valid` ignored. Release → one transfer, then IDLE.
- **Coefficient gating:** `coef_we` with addr 2 during MAC → h[2] unchanged. `coef_addr`=5 in IDLE → ignored. Same-cycle write+sample → new h used.
- **Reset mid-MAC:** assert `rst_n`=0 at k=2 → `out_valid`=0 and ALU outputs 0 immediately. After release, impulse test reproduces 0s (h cleared) until reloaded.

Source files
------------

// File: rtl/fir_mac_seq_if.sv
// Bundles every non-clock signal of the FIR engine: sample input, coefficient
// write port, ALU operand/result path and the filter result port.
// "master" is the FIR engine side; "slave" is its environment.
interface fir_mac_seq_if #(
    parameter int N = 16
);
    logic                  in_valid;
    logic signed [N-1:0]   in_data;
    logic                  in_ready;

    logic                  coef_we;
    logic [3:0]            coef_addr;
    logic signed [N-1:0]   coef_data;

    logic signed [N-1:0]   alu_a;
    logic signed [N-1:0]   alu_b;
    logic                  alu_sel;
    logic signed [31:0]    alu_out;

    logic                  out_valid;
    logic signed [31:0]    out_data;
    logic                  out_ready;

    modport master (
        input  in_valid, in_data, coef_we, coef_addr, coef_data, alu_out, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, coef_we, coef_addr, coef_data, alu_out, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data
    );
endinterface

// File: rtl/fir_mac_seq.sv
// Sequential FIR engine. Each accepted sample shifts a TAPS-deep delay line,
// then one multiply per tap is issued to an external combinational ALU and
// the products are summed into a 32-bit wrapping accumulator. The result is
// held on a valid/ready port until the consumer takes it.
module fir_mac_seq #(
    parameter int N    = 16,
    parameter int TAPS = 4
) (
    input logic           clk,
    input logic           rst_n,
    fir_mac_seq_if.master bus
);
    localparam int KW = $clog2(TAPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         k_q, k_d;
    logic signed [31:0]    acc_q, acc_d;
    logic                  out_valid_q, out_valid_d;
    logic signed [N-1:0]   x_q [TAPS];
    logic signed [N-1:0]   x_d [TAPS];
    logic signed [N-1:0]   h_q [TAPS];
    logic signed [N-1:0]   h_d [TAPS];
    logic                  coef_hit;

    // Coefficient addresses beyond the last tap are silently dropped.
    assign coef_hit = bus.coef_we && ({1'b0, bus.coef_addr} < 5'(TAPS));

    // Next-state, delay-line, coefficient and accumulator update.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        x_d         = x_q;
        h_d         = h_q;
        case (state_q)
            IDLE: begin
                if (coef_hit) begin
                    h_d[bus.coef_addr[KW-1:0]] = bus.coef_data;
                end
                if (bus.in_valid) begin
                    x_d[0] = bus.in_data;
                    for (int i = 1; i < TAPS; i++) begin
                        x_d[i] = x_q[i-1];
                    end
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = ((k_q == '0) ? 32'sd0 : acc_q) + bus.alu_out;
                if (k_q == KW'(TAPS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers; reset wipes history, coefficients and any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
                h_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            h_q         <= h_d;
        end
    end

    // Handshake and ALU operands are decoded straight from state and tap index.
    always_comb begin
        bus.in_ready = (state_q == IDLE);
        bus.alu_sel  = 1'b0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        if (state_q == MAC) begin
            bus.alu_sel = 1'b1;
            bus.alu_a   = x_q[k_q];
            bus.alu_b   = h_q[k_q];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;
endmodule
